// File: rtl/three_input_gate_pkg.sv
// Shared definitions for the three-input gate checker: function codes,
// checker FSM states and the packed vector width.
package three_input_gate_pkg;

    localparam logic [1:0] CODE_AND  = 2'b00;
    localparam logic [1:0] CODE_OR   = 2'b01;
    localparam logic [1:0] CODE_XOR  = 2'b10;
    localparam logic [1:0] CODE_NAND = 2'b11;

    // Vector layout is {code, c, b, a}
    localparam int unsigned VEC_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/three_input_gate_model.sv
// Combinational golden model of the three-input gate; reusable as the
// reference in other benches.
module three_input_gate_model
    import three_input_gate_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic [1:0] i_code,
    output logic       o_f
);

    always_comb begin
        o_f = 1'b0;
        case (i_code)
            CODE_AND:  o_f = i_a & i_b & i_c;
            CODE_OR:   o_f = i_a | i_b | i_c;
            CODE_XOR:  o_f = i_a ^ i_b ^ i_c;
            CODE_NAND: o_f = ~(i_a & i_b & i_c);
            default:   o_f = 1'b0;
        endcase
    end

endmodule

// File: rtl/three_input_gate_checker.sv
// Response checker for the three-input gate sweep: aligns golden outputs to
// the DUT through a LATENCY-deep delay line, compares and counts results.
module three_input_gate_checker
    import three_input_gate_pkg::*;
#(
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned N_VECTORS = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_c,
    input  logic [1:0]       i_code,
    input  logic             i_f,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_mismatch,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_first_fail_valid,
    output logic [4:0]       o_first_fail_vec
);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_mismatch;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_acc_cnt;
    logic               r_ff_valid;
    logic [VEC_W-1:0]   r_ff_vec;

    logic [VEC_W-1:0]   w_vec;
    logic               w_exp;
    logic               w_push;
    logic               w_last_push;
    logic               w_cmp_vld;
    logic               w_cmp_exp;
    logic [VEC_W-1:0]   w_cmp_vec;
    logic               w_cmp_fail;
    logic               w_pipe_empty;

    assign w_vec       = {i_code, i_c, i_b, i_a};
    assign w_push      = (r_state == ST_RUN) && i_valid;
    assign w_last_push = w_push && (r_acc_cnt == CNT_W'(N_VECTORS - 1));

    three_input_gate_model u_model (
        .i_a    (i_a),
        .i_b    (i_b),
        .i_c    (i_c),
        .i_code (i_code),
        .o_f    (w_exp)
    );

    // Each stage carries its own vector so gaps in i_valid never misalign compares
    if (LATENCY == 0) begin : g_comb
        assign w_cmp_vld    = w_push;
        assign w_cmp_exp    = w_exp;
        assign w_cmp_vec    = w_vec;
        assign w_pipe_empty = 1'b1;
    end else begin : g_pipe
        logic [LATENCY-1:0]            r_vld;
        logic [LATENCY-1:0]            r_exp;
        logic [LATENCY-1:0][VEC_W-1:0] r_vec;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_vld <= '0;
                r_exp <= '0;
                r_vec <= '0;
            end else begin
                r_vld[0] <= w_push;
                r_exp[0] <= w_exp;
                r_vec[0] <= w_vec;
                for (int unsigned k = 1; k < LATENCY; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    r_exp[k] <= r_exp[k-1];
                    r_vec[k] <= r_vec[k-1];
                end
            end
        end

        assign w_cmp_vld    = r_vld[LATENCY-1];
        assign w_cmp_exp    = r_exp[LATENCY-1];
        assign w_cmp_vec    = r_vec[LATENCY-1];
        assign w_pipe_empty = ~|r_vld;
    end

    assign w_cmp_fail = w_cmp_vld && (i_f != w_cmp_exp);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_mismatch <= 1'b0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_acc_cnt  <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
        end else begin
            r_mismatch <= w_cmp_fail;
            if (w_cmp_vld) begin
                if (!w_cmp_fail) begin
                    if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end else begin
                    if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    if (!r_ff_valid) begin
                        r_ff_valid <= 1'b1;
                        r_ff_vec   <= w_cmp_vec;
                    end
                end
            end

            // Start clears take priority; no compare can be pending in IDLE/DONE
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_pass_cnt <= '0;
                        r_fail_cnt <= '0;
                        r_acc_cnt  <= '0;
                        r_ff_valid <= 1'b0;
                        r_ff_vec   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_push) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                    if (w_last_push) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_fail_cnt == '0) && (r_pass_cnt == CNT_W'(N_VECTORS));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_pass             = r_pass;
    assign o_mismatch         = r_mismatch;
    assign o_pass_cnt         = r_pass_cnt;
    assign o_fail_cnt         = r_fail_cnt;
    assign o_first_fail_valid = r_ff_valid;
    assign o_first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_three_input_gate_checker.sv
// Directed bench for three_input_gate_checker: four parameterisations driven
// by a behavioural gate whose output can be faulted per instance.
module tb_three_input_gate_checker;

    logic       clk;
    logic       rst;
    logic       st  [4];
    logic       vl  [4];
    logic [4:0] vec [4];
    logic       f   [4];
    int         fmode [4];

    logic       bsy [4];
    logic       dn  [4];
    logic       ps  [4];
    logic       mm  [4];
    logic       ffv [4];
    logic [4:0] ffvec [4];

    logic [7:0] pc0, fc0, pc1, fc1, pc3, fc3;
    logic [3:0] pc2, fc2;

    logic [2:0] fp [4];

    int n_checks;
    int n_pass;
    int mmcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: correct gate, 1: output inverted for vector 22, 2: stuck at 0
    function automatic logic dut_out(input logic [4:0] v, input int m);
        logic g;
        case (v[4:3])
            2'b00:   g = &v[2:0];
            2'b01:   g = |v[2:0];
            2'b10:   g = ^v[2:0];
            default: g = ~&v[2:0];
        endcase
        if (m == 1 && v == 5'd22) g = ~g;
        else if (m == 2) g = 1'b0;
        return g;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) fp[i] <= {fp[i][1:0], dut_out(vec[i], fmode[i])};
    end

    assign f[0] = fp[0][0];
    assign f[1] = fp[1][2];
    assign f[2] = fp[2][0];
    assign f[3] = dut_out(vec[3], fmode[3]);

    three_input_gate_checker u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_valid(vl[0]),
        .i_a(vec[0][0]), .i_b(vec[0][1]), .i_c(vec[0][2]), .i_code(vec[0][4:3]), .i_f(f[0]),
        .o_busy(bsy[0]), .o_done(dn[0]), .o_pass(ps[0]), .o_mismatch(mm[0]),
        .o_pass_cnt(pc0), .o_fail_cnt(fc0),
        .o_first_fail_valid(ffv[0]), .o_first_fail_vec(ffvec[0])
    );

    three_input_gate_checker #(.LATENCY(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_valid(vl[1]),
        .i_a(vec[1][0]), .i_b(vec[1][1]), .i_c(vec[1][2]), .i_code(vec[1][4:3]), .i_f(f[1]),
        .o_busy(bsy[1]), .o_done(dn[1]), .o_pass(ps[1]), .o_mismatch(mm[1]),
        .o_pass_cnt(pc1), .o_fail_cnt(fc1),
        .o_first_fail_valid(ffv[1]), .o_first_fail_vec(ffvec[1])
    );

    three_input_gate_checker #(.CNT_W(4), .N_VECTORS(15)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_valid(vl[2]),
        .i_a(vec[2][0]), .i_b(vec[2][1]), .i_c(vec[2][2]), .i_code(vec[2][4:3]), .i_f(f[2]),
        .o_busy(bsy[2]), .o_done(dn[2]), .o_pass(ps[2]), .o_mismatch(mm[2]),
        .o_pass_cnt(pc2), .o_fail_cnt(fc2),
        .o_first_fail_valid(ffv[2]), .o_first_fail_vec(ffvec[2])
    );

    three_input_gate_checker #(.LATENCY(0)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(st[3]), .i_valid(vl[3]),
        .i_a(vec[3][0]), .i_b(vec[3][1]), .i_c(vec[3][2]), .i_code(vec[3][4:3]), .i_f(f[3]),
        .o_busy(bsy[3]), .o_done(dn[3]), .o_pass(ps[3]), .o_mismatch(mm[3]),
        .o_pass_cnt(pc3), .o_fail_cnt(fc3),
        .o_first_fail_valid(ffv[3]), .o_first_fail_vec(ffvec[3])
    );

    task automatic tick(input int i);
        @(negedge clk);
        if (mm[i]) mmcnt++;
    endtask

    task automatic sweep(input int i, input int n, input bit gap);
        st[i] = 1'b1;
        vl[i] = 1'b0;
        tick(i);
        st[i] = 1'b0;
        for (int v = 0; v < n; v++) begin
            vec[i] = 5'(v);
            vl[i]  = 1'b1;
            tick(i);
            if (gap) begin
                vl[i] = 1'b0;
                tick(i);
            end
        end
        vl[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        for (int k = 0; k < budget && !dn[i]; k++) tick(i);
        n_checks++;
        if (dn[i] !== 1'b1) $display("FAIL done_timeout[%0d]: o_done=%b required 1", i, dn[i]);
        else n_pass++;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({bsy[0], dn[0], ps[0], mm[0], ffv[0]} !== 5'b0)
            $display("FAIL reset_flags: got %b required 00000", {bsy[0], dn[0], ps[0], mm[0], ffv[0]});
        else n_pass++;
        n_checks++;
        if (pc0 !== 8'd0) $display("FAIL reset_pass_cnt: got %0d required 0", pc0); else n_pass++;
        n_checks++;
        if (fc0 !== 8'd0) $display("FAIL reset_fail_cnt: got %0d required 0", fc0); else n_pass++;
    endtask

    task automatic test_back_to_back;
        fmode[0] = 0;
        mmcnt = 0;
        sweep(0, 32, 1'b0);
        wait_done(0, 20);
        n_checks++;
        if (pc0 !== 8'd32) $display("FAIL b2b_pass_cnt: got %0d required 32", pc0); else n_pass++;
        n_checks++;
        if (fc0 !== 8'd0) $display("FAIL b2b_fail_cnt: got %0d required 0", fc0); else n_pass++;
        n_checks++;
        if (ps[0] !== 1'b1) $display("FAIL b2b_pass: got %b required 1", ps[0]); else n_pass++;
        n_checks++;
        if (ffv[0] !== 1'b0) $display("FAIL b2b_ff_valid: got %b required 0", ffv[0]); else n_pass++;
        n_checks++;
        if (bsy[0] !== 1'b0) $display("FAIL b2b_busy: got %b required 0", bsy[0]); else n_pass++;
        n_checks++;
        if (mmcnt !== 0) $display("FAIL b2b_mismatch_pulses: got %0d required 0", mmcnt); else n_pass++;
    endtask

    task automatic test_single_fault;
        fmode[0] = 1;
        mmcnt = 0;
        sweep(0, 32, 1'b0);
        wait_done(0, 20);
        n_checks++;
        if (fc0 !== 8'd1) $display("FAIL fault_fail_cnt: got %0d required 1", fc0); else n_pass++;
        n_checks++;
        if (pc0 !== 8'd31) $display("FAIL fault_pass_cnt: got %0d required 31", pc0); else n_pass++;
        n_checks++;
        if (ffv[0] !== 1'b1) $display("FAIL fault_ff_valid: got %b required 1", ffv[0]); else n_pass++;
        n_checks++;
        if (ffvec[0] !== 5'd22) $display("FAIL fault_ff_vec: got %0d required 22", ffvec[0]); else n_pass++;
        n_checks++;
        if (ps[0] !== 1'b0) $display("FAIL fault_pass: got %b required 0", ps[0]); else n_pass++;
        n_checks++;
        if (mmcnt !== 1) $display("FAIL fault_mismatch_pulses: got %0d required 1", mmcnt); else n_pass++;
        fmode[0] = 0;
    endtask

    task automatic test_reset_mid_sweep;
        fmode[0] = 0;
        st[0] = 1'b1;
        tick(0);
        st[0] = 1'b0;
        for (int v = 0; v < 10; v++) begin
            vec[0] = 5'(v);
            vl[0]  = 1'b1;
            tick(0);
        end
        n_checks++;
        if (pc0 !== 8'd9) $display("FAIL mid_pass_cnt: got %0d required 9", pc0); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bsy[0], dn[0], ps[0], mm[0], ffv[0]} !== 5'b0)
            $display("FAIL mid_rst_flags: got %b required 00000", {bsy[0], dn[0], ps[0], mm[0], ffv[0]});
        else n_pass++;
        n_checks++;
        if (pc0 !== 8'd0) $display("FAIL mid_rst_pass_cnt: got %0d required 0", pc0); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        vec[0] = 5'd3;
        vl[0]  = 1'b1;
        for (int k = 0; k < 3; k++) tick(0);
        vl[0] = 1'b0;
        tick(0);
        n_checks++;
        if ({bsy[0], pc0} !== {1'b0, 8'd0}) $display("FAIL idle_ignores_valid: busy=%b pass_cnt=%0d required 0/0", bsy[0], pc0);
        else n_pass++;
        sweep(0, 32, 1'b0);
        wait_done(0, 20);
        n_checks++;
        if (pc0 !== 8'd32) $display("FAIL post_rst_pass_cnt: got %0d required 32", pc0); else n_pass++;
        n_checks++;
        if (ps[0] !== 1'b1) $display("FAIL post_rst_pass: got %b required 1", ps[0]); else n_pass++;
    endtask

    task automatic test_gap_drain;
        fmode[1] = 0;
        mmcnt = 0;
        sweep(1, 32, 1'b1);
        for (int k = 0; k < 4; k++) begin
            vec[1] = 5'($urandom_range(0, 31));
            vl[1]  = 1'b1;
            tick(1);
        end
        vl[1] = 1'b0;
        wait_done(1, 20);
        for (int k = 0; k < 4; k++) tick(1);
        n_checks++;
        if (pc1 !== 8'd32) $display("FAIL gap_pass_cnt: got %0d required 32", pc1); else n_pass++;
        n_checks++;
        if (fc1 !== 8'd0) $display("FAIL gap_fail_cnt: got %0d required 0", fc1); else n_pass++;
        n_checks++;
        if (ps[1] !== 1'b1) $display("FAIL gap_pass: got %b required 1", ps[1]); else n_pass++;
    endtask

    task automatic test_stuck_zero;
        // Expected-1 vectors among 0..14: 7 (AND) and 9..14 (OR)
        fmode[2] = 2;
        sweep(2, 15, 1'b0);
        wait_done(2, 20);
        n_checks++;
        if (fc2 !== 4'd7) $display("FAIL stuck_fail_cnt: got %0d required 7", fc2); else n_pass++;
        n_checks++;
        if (pc2 !== 4'd8) $display("FAIL stuck_pass_cnt: got %0d required 8", pc2); else n_pass++;
        n_checks++;
        if ({ffv[2], ffvec[2]} !== {1'b1, 5'd7}) $display("FAIL stuck_first_fail: valid=%b vec=%0d required 1/7", ffv[2], ffvec[2]);
        else n_pass++;
        n_checks++;
        if (ps[2] !== 1'b0) $display("FAIL stuck_pass: got %b required 0", ps[2]); else n_pass++;
    endtask

    task automatic test_restart_in_done;
        fmode[2] = 0;
        sweep(2, 15, 1'b0);
        wait_done(2, 20);
        n_checks++;
        if (pc2 !== 4'd15) $display("FAIL full_pass_cnt: got %0d required 15", pc2); else n_pass++;
        n_checks++;
        if ({ps[2], fc2} !== {1'b1, 4'd0}) $display("FAIL full_pass: pass=%b fail_cnt=%0d required 1/0", ps[2], fc2); else n_pass++;
        st[2] = 1'b1;
        tick(2);
        st[2] = 1'b0;
        n_checks++;
        if ({pc2, fc2} !== 8'd0) $display("FAIL restart_counters: pass_cnt=%0d fail_cnt=%0d required 0/0", pc2, fc2); else n_pass++;
        n_checks++;
        if ({bsy[2], dn[2], ps[2], ffv[2]} !== 4'b1000)
            $display("FAIL restart_flags: got %b required 1000", {bsy[2], dn[2], ps[2], ffv[2]});
        else n_pass++;
    endtask

    task automatic test_latency0;
        fmode[3] = 0;
        mmcnt = 0;
        sweep(3, 32, 1'b0);
        n_checks++;
        if ({bsy[3], dn[3]} !== 2'b10) $display("FAIL lat0_drain: busy/done=%b required 10", {bsy[3], dn[3]}); else n_pass++;
        tick(3);
        n_checks++;
        if ({bsy[3], dn[3]} !== 2'b01) $display("FAIL lat0_done: busy/done=%b required 01", {bsy[3], dn[3]}); else n_pass++;
        n_checks++;
        if (pc3 !== 8'd32) $display("FAIL lat0_pass_cnt: got %0d required 32", pc3); else n_pass++;
        n_checks++;
        if ({ps[3], fc3} !== {1'b1, 8'd0}) $display("FAIL lat0_pass: pass=%b fail_cnt=%0d required 1/0", ps[3], fc3); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mmcnt    = 0;
        rst      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st[i]    = 1'b0;
            vl[i]    = 1'b0;
            vec[i]   = 5'd0;
            fmode[i] = 0;
        end
        #3;
        test_reset;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_back_to_back;
        test_single_fault;
        test_reset_mid_sweep;
        test_gap_drain;
        test_stuck_zero;
        test_restart_in_done;
        test_latency0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
